// File: rtl/display_pkg.sv
// Shared 7-segment table and types for the display encoder/reader pair.
// Pattern word is {a,b,c,d,e,f,g} with segment a in bit 6.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_PRESENT,
    S_HOLD
  } rd_state_e;

  typedef struct packed {
    logic       err;
    logic [4:0] code;
  } lookup_t;

  // 0..15 hex glyphs, 16..31 letters and symbols
  localparam logic [6:0] SEG_TABLE [32] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
    7'h0E, 7'h37, 7'h67, 7'h3E, 7'h15, 7'h1D, 7'h05, 7'h0F,
    7'h1C, 7'h3B, 7'h76, 7'h08, 7'h40, 7'h48, 7'h63, 7'h38
  };

  function automatic lookup_t seg_lookup(input logic [6:0] p);
    lookup_t r;
    r.err  = 1'b1;
    r.code = '0;
    for (int i = 31; i >= 0; i--) begin
      if (SEG_TABLE[i] == p) begin
        r.err  = 1'b0;
        r.code = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_sync_debounce.sv
// Two-flop synchronizer plus candidate/counter stability tracker
// for the seven segment lines.
module seg_sync_debounce
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [6:0] pattern,
  output logic       changed,
  output logic       stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync1_q, sync2_q;
  logic [6:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pattern = sync2_q;
  assign changed = (sync2_q != cand_q);
  assign stable  = !changed && (cnt_q == CNT_HIT);

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (changed) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/display_reader.sv
// Decodes a debounced 7-segment pattern back into its 5-bit code
// and offers it once per stable pattern over valid/ready.
module display_reader
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  output logic [4:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       code_err,
  output logic       blank
);

  logic [6:0] pattern;
  logic       changed;
  logic       stable;
  logic       settled;
  lookup_t    lk;

  rd_state_e  state_q, state_d;
  logic [4:0] code_q, code_d;
  logic       err_q, err_d;
  logic       blank_q, blank_d;
  logic       restart_q, restart_d;
  logic       seen_q, seen_d;
  logic [6:0] last_q, last_d;

  seg_sync_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in ({seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}),
    .pattern(pattern),
    .changed(changed),
    .stable (stable)
  );

  assign lk = seg_lookup(pattern);

  // seen_q remembers a stable pulse that fired while a code was pending
  assign settled = stable || (seen_q && !changed);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    err_d     = err_q;
    blank_d   = blank_q;
    restart_d = restart_q;
    last_d    = last_q;
    seen_d    = changed ? 1'b0 : (stable ? 1'b1 : seen_q);
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (changed) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settled) begin
          if (pattern == SEG_BLANK) begin
            blank_d = 1'b1;
            last_d  = pattern;
            state_d = S_IDLE;
          end else begin
            blank_d = 1'b0;
            if (pattern == last_q) begin
              state_d = S_HOLD;
            end else begin
              code_d  = lk.code;
              err_d   = lk.err;
              last_d  = pattern;
              state_d = S_PRESENT;
            end
          end
        end
      end
      S_PRESENT: begin
        if (changed) restart_d = 1'b1;
        if (code_ready) begin
          restart_d = 1'b0;
          state_d   = (restart_q || changed) ? S_SETTLE : S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      err_q     <= 1'b0;
      blank_q   <= 1'b0;
      restart_q <= 1'b0;
      seen_q    <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      err_q     <= err_d;
      blank_q   <= blank_d;
      restart_q <= restart_d;
      seen_q    <= seen_d;
      last_q    <= last_d;
    end
  end

  assign code_valid = (state_q == S_PRESENT);
  assign code_out   = code_q;
  assign code_err   = err_q;
  assign blank      = blank_q;

endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader: expected codes queued on
// stimulus, popped at each valid/ready handshake.
module tb_display_reader;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [4:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       code_err;
  logic       blank;

  int checks = 0;
  int failures = 0;
  int emis = 0;
  logic [5:0] exp_q[$];

  logic [6:0] glyph [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  display_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_a     (seg_a),
    .seg_b     (seg_b),
    .seg_c     (seg_c),
    .seg_d     (seg_d),
    .seg_e     (seg_e),
    .seg_f     (seg_f),
    .seg_g     (seg_g),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .code_err  (code_err),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_seg(input logic [6:0] p);
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = p;
  endtask

  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      emis++;
      if (exp_q.size() == 0) chk("unexpected_emit", 1, 0);
      else chk("code", {26'd0, code_err, code_out}, {26'd0, exp_q.pop_front()});
    end
  end

  task automatic measure(output int first, output int nv);
    first = 99;
    nv = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (code_valid) begin
        nv++;
        if (first == 99) first = n;
      end
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!code_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!code_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int first, nv, e0, saw, bad;
    rst_n = 1'b0;
    code_ready = 1'b1;
    set_seg(7'h30);
    idle(3);
    chk("rst_valid", code_valid, 0);
    chk("rst_code", code_out, 0);
    chk("rst_err", code_err, 0);
    chk("rst_blank", blank, 0);

    exp_q.push_back({1'b0, 5'd1});
    @(negedge clk) rst_n = 1'b1;
    measure(first, nv);
    chk("latency", first, STABLE + 3);
    chk("one_cycle", nv, 1);

    // sweep the sixteen hex glyphs
    e0 = emis;
    for (int i = 0; i < 16; i++) begin
      set_seg(glyph[i]);
      exp_q.push_back({1'b0, 5'(i)});
      idle(10);
    end
    chk("sweep_count", emis - e0, 16);
    chk("sweep_drained", exp_q.size(), 0);

    // short glitch must not re-emit
    set_seg(7'h7E);
    exp_q.push_back({1'b0, 5'd0});
    idle(10);
    e0 = emis;
    saw = 0;
    set_seg(7'h7F);
    idle(2);
    set_seg(7'h7E);
    for (int n = 0; n < 15; n++) begin
      idle(1);
      if (code_valid) saw = 1;
    end
    chk("glitch_valid", saw, 0);
    chk("glitch_count", emis - e0, 0);

    // backpressure with a change while waiting
    code_ready = 1'b0;
    set_seg(7'h5B);
    exp_q.push_back({1'b0, 5'd5});
    wait_valid();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) set_seg(7'h4F);
      idle(1);
      if (!code_valid || code_out != 5'd5 || code_err) bad = 1;
    end
    chk("hold_steady", bad, 0);
    exp_q.push_back({1'b0, 5'd14});
    code_ready = 1'b1;
    first = 99;
    for (int n = 1; n <= 8; n++) begin
      idle(1);
      if (n > 1 && code_valid && first == 99) first = n;
    end
    chk("resume_in_time", (first <= STABLE + 1) ? 1 : 0, 1);
    idle(5);

    // unknown pattern, blank, then recovery
    set_seg(7'h01);
    exp_q.push_back({1'b1, 5'd0});
    idle(10);
    chk("err_not_blank", blank, 0);
    e0 = emis;
    set_seg(7'h00);
    idle(10);
    chk("blank_set", blank, 1);
    chk("blank_no_emit", emis - e0, 0);
    set_seg(7'h30);
    exp_q.push_back({1'b0, 5'd1});
    idle(10);
    chk("blank_clear", blank, 0);

    // async reset while a code is pending
    code_ready = 1'b0;
    set_seg(7'h6D);
    exp_q.push_back({1'b0, 5'd2});
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", code_valid, 0);
    chk("arst_code", code_out, 0);
    chk("arst_err", code_err, 0);
    chk("arst_blank", blank, 0);
    exp_q.delete();
    idle(2);
    code_ready = 1'b1;
    exp_q.push_back({1'b0, 5'd2});
    @(negedge clk) rst_n = 1'b1;
    measure(first, nv);
    chk("rst_latency", first, STABLE + 3);
    chk("rst_one_cycle", nv, 1);

    idle(5);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
